ws2812_rx: RTL and testbench

//   Decoder for the single-wire WS2812 strip waveform our ice40_top drives on PIN_1.

---
 rtl/ws2812_pkg.sv | 26 ++
 rtl/ws2812_din_sync.sv | 28 ++
 rtl/ws2812_rx.sv | 185 ++++++++++++++++++
 tb/tb_ws2812_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - WS2812 line timing constants, GRB layout and receiver state encoding
package ws2812_pkg;

    localparam int CLK_HZ   = 16_000_000;
    localparam int T0H_NS   = 400;
    localparam int T1H_NS   = 800;
    localparam int RESET_NS = 50_000;

    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } rx_state_t;

    // Rounds up so a gap is never judged shorter than its nominal time.
    function automatic int ns_to_cycles(input int ns, input int clk_hz);
        longint prod;
        prod = longint'(ns) * longint'(clk_hz);
        return int'((prod + longint'(999_999_999)) / longint'(1_000_000_000));
    endfunction

endpackage

// File: rtl/ws2812_din_sync.sv
// rtl/ws2812_din_sync.sv - two-flop synchronizer for the strip line with edge strobes aligned to din_s
module ws2812_din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta;

    // Strobes are computed from the stage ahead so they coincide with the din_s transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            din_s <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            din_s <= meta;
            rise  <= meta & ~din_s;
            fall  <= ~meta & din_s;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 line decoder recovering GRB pixel words and frame-latch events
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_SAMPLE     = 10,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = ns_to_cycles(RESET_NS, CLK_HZ),
    parameter int MAX_PIXELS   = 512,
    parameter int IDX_W        = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pix_grb,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic             latch,
    output logic             frame_err,
    output logic             armed
);

    localparam int HCNT_W = $clog2(MAX_HIGH + 2);
    localparam int LCNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HCNT_W-1:0] HC_SAMPLE = HCNT_W'(T_SAMPLE);
    localparam logic [HCNT_W-1:0] HC_MIN    = HCNT_W'(MIN_HIGH);
    localparam logic [HCNT_W-1:0] HC_MAX    = HCNT_W'(MAX_HIGH);
    localparam logic [LCNT_W-1:0] LC_GAP    = LCNT_W'(RESET_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LC_SAT    = LCNT_W'(RESET_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_PIXELS - 1);

    logic din_s, rise, fall;

    ws2812_din_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_t         state, state_n;
    logic [HCNT_W-1:0] hcnt, hcnt_n;
    logic [LCNT_W-1:0] lcnt, lcnt_n;
    logic [23:0]       shift, shift_n;
    logic [4:0]        bitcnt, bitcnt_n;
    logic              full, full_n;
    logic [23:0]       grb_n;
    logic              valid_n, latch_n, err_n, armed_n;
    logic [IDX_W-1:0]  idx_n;
    logic              shift_en, shift_bit;

    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        lcnt_n    = lcnt;
        shift_n   = shift;
        bitcnt_n  = bitcnt;
        full_n    = full;
        grb_n     = pix_grb;
        valid_n   = 1'b0;
        idx_n     = pix_index;
        latch_n   = 1'b0;
        err_n     = frame_err;
        armed_n   = armed;
        shift_en  = 1'b0;
        shift_bit = 1'b0;

        // A partial-pixel error is shown only for the latch cycle itself.
        if (latch)
            err_n = 1'b0;

        if (pix_valid) begin
            if (pix_index == IDX_LAST)
                full_n = 1'b1;
            else
                idx_n = pix_index + 1'b1;
        end

        case (state)
            ST_ARM: begin
                if (din_s) begin
                    lcnt_n = '0;
                end else if (lcnt == LC_GAP) begin
                    armed_n  = 1'b1;
                    state_n  = ST_IDLE;
                    lcnt_n   = LC_SAT;
                    bitcnt_n = '0;
                    idx_n    = '0;
                    full_n   = 1'b0;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    hcnt_n  = '0;
                    state_n = ST_HIGH;
                end else if (lcnt == LC_GAP) begin
                    lcnt_n = LC_SAT;
                    if (bitcnt != '0 || pix_index != '0 || full) begin
                        latch_n  = 1'b1;
                        err_n    = (bitcnt != '0);
                        idx_n    = '0;
                        bitcnt_n = '0;
                        full_n   = 1'b0;
                    end
                end else if (lcnt != LC_SAT) begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (hcnt > HC_MAX) begin
                    err_n    = 1'b1;
                    bitcnt_n = '0;
                    lcnt_n   = '0;
                    state_n  = ST_ARM;
                end else if (fall) begin
                    state_n = ST_IDLE;
                    if (hcnt < HC_MIN) begin
                        err_n = 1'b1;
                    end else begin
                        lcnt_n = '0;
                        if (hcnt <= HC_SAMPLE)
                            shift_en = 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                    if (hcnt == HC_SAMPLE) begin
                        shift_en  = 1'b1;
                        shift_bit = 1'b1;
                    end
                end
            end
            default: state_n = ST_ARM;
        endcase

        // Overrides the overlong-pulse bitcnt clear only when both happen together, which the counts rule out.
        if (shift_en) begin
            shift_n = {shift[22:0], shift_bit};
            if (bitcnt == 5'd23) begin
                grb_n    = shift_n;
                valid_n  = 1'b1;
                bitcnt_n = '0;
                if (full)
                    err_n = 1'b1;
            end else begin
                bitcnt_n = bitcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARM;
            hcnt      <= '0;
            lcnt      <= '0;
            shift     <= '0;
            bitcnt    <= '0;
            full      <= 1'b0;
            pix_grb   <= '0;
            pix_valid <= 1'b0;
            pix_index <= '0;
            latch     <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            hcnt      <= hcnt_n;
            lcnt      <= lcnt_n;
            shift     <= shift_n;
            bitcnt    <= bitcnt_n;
            full      <= full_n;
            pix_grb   <= grb_n;
            pix_valid <= valid_n;
            pix_index <= idx_n;
            latch     <= latch_n;
            frame_err <= err_n;
            armed     <= armed_n;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx with a pixel scoreboard and frame vector table
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pix_grb;
    logic        pix_valid;
    logic [1:0]  pix_index;
    logic        latch;
    logic        frame_err;
    logic        armed;

    int checks = 0;
    int errors = 0;
    int latch_cnt = 0;
    logic latch_err = 1'b0;

    typedef struct {
        logic [23:0] grb;
        int          idx;
        logic        err;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [23:0] grb;
        int          nbits;
        int          glitch_bit;
        logic        exp_pix;
        logic        exp_pix_err;
        logic        exp_latch_err;
    } vec_t;

    vec_t vecs[4];

    ws2812_rx #(
        .MAX_PIXELS (4),
        .IDX_W      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .pix_grb   (pix_grb),
        .pix_valid (pix_valid),
        .pix_index (pix_index),
        .latch     (latch),
        .frame_err (frame_err),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_pix_valid", pix_grb, 0);
                    if (pix_grb == 0) chk("unexpected_pix_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pix_grb", pix_grb, e.grb);
                    chk("pix_index", pix_index, e.idx);
                    chk("pix_err", frame_err, e.err);
                end
            end
            if (latch) begin
                latch_cnt++;
                latch_err = frame_err;
                chk("latch_not_with_valid", pix_valid, 0);
            end
        end
    end

    task automatic send_bit(input logic b, input logic glitch);
        int lo;
        lo = b ? 7 : 14;
        din = 1'b1;
        repeat (b ? 13 : 6) @(negedge clk);
        din = 1'b0;
        if (glitch) begin
            repeat (3) @(negedge clk);
            din = 1'b1;
            @(negedge clk);
            din = 1'b0;
            repeat (lo - 4) @(negedge clk);
        end else begin
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [23:0] grb, input int nbits, input int gbit);
        for (int i = 0; i < nbits; i++)
            send_bit(grb[23 - i], i == gbit);
    endtask

    task automatic push(input logic [23:0] grb, input int idx, input logic err);
        exp_t e;
        e.grb = grb;
        e.idx = idx;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int lc;
        logic [23:0] pix3 [3];

        vecs[0] = '{24'h123456, 24, -1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{24'hA5C33C, 24,  5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{24'h3FF000, 10, -1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{24'h000001, 24, -1, 1'b1, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        chk("rst_pix_grb", pix_grb, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_index", pix_index, 0);
        chk("rst_latch", latch, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_armed", armed, 0);

        rst_n = 1'b1;
        cnt = 0;
        while (!armed && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt < 795 || cnt > 810) begin
            errors++;
            $display("FAIL arm_latency: got %0d cycles expected 795..810", cnt);
        end
        chk("no_latch_from_arm", latch_cnt, 0);
        gap(20);

        for (int v = 0; v < 4; v++) begin
            lc = latch_cnt;
            if (vecs[v].exp_pix) push(vecs[v].grb, 0, vecs[v].exp_pix_err);
            send_frame(vecs[v].grb, vecs[v].nbits, vecs[v].glitch_bit);
            gap(900);
            chk("vec_latch_count", latch_cnt, lc + 1);
            chk("vec_latch_err", latch_err, vecs[v].exp_latch_err);
            chk("vec_err_after_latch", frame_err, 0);
            chk("vec_index_after_latch", pix_index, 0);
            chk("vec_queue_drained", q.size(), 0);
        end

        pix3[0] = 24'hFF0000;
        pix3[1] = 24'h00FF00;
        pix3[2] = 24'h0000FF;
        lc = latch_cnt;
        for (int i = 0; i < 3; i++) begin
            push(pix3[i], i, 1'b0);
            send_frame(pix3[i], 24, -1);
        end
        gap(900);
        chk("three_latch", latch_cnt, lc + 1);
        chk("three_index_reset", pix_index, 0);
        chk("three_drained", q.size(), 0);

        lc = latch_cnt;
        for (int i = 0; i < 5; i++) begin
            push(24'h100000 + 24'(i), (i < 4) ? i : 3, i == 4);
            send_frame(24'h100000 + 24'(i), 24, -1);
        end
        gap(900);
        chk("ovf_latch", latch_cnt, lc + 1);
        chk("ovf_index_reset", pix_index, 0);
        chk("ovf_err_cleared", frame_err, 0);

        lc = latch_cnt;
        send_frame(24'hFFFFFF, 5, -1);
        din = 1'b1;
        repeat (40) @(negedge clk);
        din = 1'b0;
        repeat (2) @(negedge clk);
        chk("long_err", frame_err, 1);
        gap(900);
        chk("long_no_latch", latch_cnt, lc);
        chk("long_armed", armed, 1);
        push(24'h0F0F0F, 0, 1'b1);
        send_frame(24'h0F0F0F, 24, -1);
        gap(900);
        chk("long_next_latch", latch_cnt, lc + 1);
        chk("long_err_cleared", frame_err, 0);

        push(24'h5A5A5A, 0, 1'b0);
        send_frame(24'h5A5A5A, 24, -1);
        send_frame(24'hFFFFFF, 12, -1);
        rst_n = 1'b0;
        din = 1'b0;
        #1;
        chk("midrst_grb", pix_grb, 0);
        chk("midrst_index", pix_index, 0);
        chk("midrst_armed", armed, 0);
        chk("midrst_err", frame_err, 0);
        chk("midrst_valid", pix_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lc = latch_cnt;
        send_frame(24'h777777, 24, -1);
        gap(900);
        chk("rerst_armed", armed, 1);
        chk("rerst_no_latch", latch_cnt, lc);
        push(24'hC0FFEE, 0, 1'b0);
        send_frame(24'hC0FFEE, 24, -1);
        gap(900);
        chk("rerst_latch", latch_cnt, lc + 1);
        chk("final_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
